// File: rtl/adc_sar_sequencer_pkg.sv
// Shared definitions for the SAR ADC sequencer: FSM state codes,
// averaging-select encodings and the decisions-per-LSB-step lookup.
package adc_sar_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SAMPLE  = 2'd1;
    localparam state_t ST_CONVERT = 2'd2;
    localparam state_t ST_HOLD    = 2'd3;

    typedef enum logic [2:0] {
        AVG_1  = 3'd0,
        AVG_3  = 3'd1,
        AVG_7  = 3'd2,
        AVG_15 = 3'd3,
        AVG_31 = 3'd4
    } avg_sel_t;

    // Wide enough to hold the largest decision count (31).
    localparam int VOTE_W = 5;

    // Number of comparator decisions taken per LSB step; reserved codes fall back to one.
    function automatic logic [VOTE_W-1:0] avg_count(input logic [2:0] sel);
        case (sel)
            AVG_3:   return 5'd3;
            AVG_7:   return 5'd7;
            AVG_15:  return 5'd15;
            AVG_31:  return 5'd31;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/adc_sar_sequencer_if.sv
// Weight-table write port and result valid/ready handshake of the SAR sequencer.
interface adc_sar_sequencer_if #(
    parameter int MATRIX_BITS = 12,
    parameter int NUM_STEPS   = 15
);
    localparam int ADDR_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    logic                   weight_wr_en_in;
    logic [ADDR_W-1:0]      weight_addr_in;
    logic [MATRIX_BITS-1:0] weight_data_in;
    logic [MATRIX_BITS-1:0] result_out;
    logic                   result_valid_out;
    logic                   result_ready_in;

    modport slave (
        input  weight_wr_en_in, weight_addr_in, weight_data_in, result_ready_in,
        output result_out, result_valid_out
    );

    modport master (
        output weight_wr_en_in, weight_addr_in, weight_data_in, result_ready_in,
        input  result_out, result_valid_out
    );
endinterface

// File: rtl/adc_sar_lsb_vote.sv
// Majority vote over the repeated comparator decisions of one LSB step.
module adc_sar_lsb_vote
    import adc_sar_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              comparator_in,
    input  logic [VOTE_W-1:0] num_decisions,
    output logic              step_done,
    output logic              decision
);
    localparam int TOTAL_W = VOTE_W + 1;

    logic [VOTE_W-1:0]  count;
    logic [VOTE_W-1:0]  ones;
    logic [TOTAL_W-1:0] total;

    // Count elapsed cycles and "keep" votes; both restart after every LSB step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ones  <= '0;
        end else if (!active || step_done) begin
            count <= '0;
            ones  <= '0;
        end else begin
            count <= count + VOTE_W'(1);
            ones  <= ones + VOTE_W'(comparator_in);
        end
    end

    // The current cycle's vote is folded in so the decision is ready on the closing edge.
    assign step_done = active && (count == num_decisions - VOTE_W'(1));
    assign total     = {1'b0, ones} + TOTAL_W'(comparator_in);
    assign decision  = total > TOTAL_W'(num_decisions >> 1);

endmodule

// File: rtl/adc_sar_sequencer.sv
// SAR ADC conversion sequencer: sample, binary-weighted search with a
// programmable weight table, majority-voted LSB steps and a result handshake.
module adc_sar_sequencer
    import adc_sar_sequencer_pkg::*;
#(
    parameter int MATRIX_BITS   = 12,
    parameter int NUM_STEPS     = 15,
    parameter int LSB_STEPS     = 4,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comparator_in,
    input  logic                   start_in,
    input  logic                   continuous_in,
    input  logic [2:0]             avg_control_in,
    adc_sar_sequencer_if.slave     bus,
    output logic                   sample_out,
    output logic                   sample_out_n,
    output logic                   enable_loop_out,
    output logic [MATRIX_BITS-1:0] nswitch_out,
    output logic [MATRIX_BITS-1:0] pswitch_out,
    output logic                   busy_out,
    output logic                   overrun_out
);
    localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int SC_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_STEP   = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0] FIRST_LSB   = IDX_W'(NUM_STEPS - LSB_STEPS);
    localparam logic [SC_W-1:0]  LAST_SAMPLE = SC_W'(SAMPLE_CYCLES - 1);

    state_t                 state;
    logic [SC_W-1:0]        sample_count;
    logic [IDX_W-1:0]       step;
    logic [MATRIX_BITS-1:0] data;
    logic [MATRIX_BITS-1:0] result;
    logic                   valid;
    logic                   overrun;
    logic [2:0]             avg_sel;
    logic [MATRIX_BITS-1:0] weight [NUM_STEPS];

    logic [MATRIX_BITS:0]   sum;
    logic [MATRIX_BITS-1:0] trial;
    logic [MATRIX_BITS-1:0] final_data;
    logic                   lsb_step;
    logic                   step_done;
    logic                   decision;
    logic                   conv_done;
    logic                   vote_done;
    logic                   vote_decision;

    // One-hot power-of-two weights from the MSB down; steps past the matrix width add nothing.
    function automatic logic [MATRIX_BITS-1:0] default_weight(input int i);
        logic [MATRIX_BITS-1:0] w;
        w = '0;
        if (i < MATRIX_BITS) w[MATRIX_BITS-1-i] = 1'b1;
        return w;
    endfunction

    // Redundant weight tables can sum past full scale, so the trial code saturates.
    assign sum        = {1'b0, data} + {1'b0, weight[step]};
    assign trial      = sum[MATRIX_BITS] ? '1 : sum[MATRIX_BITS-1:0];
    assign lsb_step   = (step >= FIRST_LSB);
    assign step_done  = lsb_step ? vote_done : 1'b1;
    assign decision   = lsb_step ? vote_decision : comparator_in;
    assign conv_done  = (state == ST_CONVERT) && step_done && (step == LAST_STEP);
    assign final_data = decision ? trial : data;

    adc_sar_lsb_vote u_lsb_vote (
        .clk           (clk),
        .rst_n         (rst_n),
        .active        ((state == ST_CONVERT) && lsb_step),
        .comparator_in (comparator_in),
        .num_decisions (avg_count(avg_sel)),
        .step_done     (vote_done),
        .decision      (vote_decision)
    );

    // Sequence IDLE -> SAMPLE -> CONVERT -> HOLD and walk the successive-approximation register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sample_count <= '0;
            step         <= '0;
            data         <= '0;
            avg_sel      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sample_count <= '0;
                    if (start_in || continuous_in) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    data <= '0;
                    if (sample_count == LAST_SAMPLE) begin
                        avg_sel <= avg_control_in;
                        step    <= '0;
                        state   <= ST_CONVERT;
                    end else begin
                        sample_count <= sample_count + SC_W'(1);
                    end
                end
                ST_CONVERT: begin
                    if (step_done) begin
                        if (decision) data <= trial;
                        if (step == LAST_STEP) state <= ST_HOLD;
                        else step <= step + IDX_W'(1);
                    end
                end
                default: begin
                    sample_count <= '0;
                    state        <= continuous_in ? ST_SAMPLE : ST_IDLE;
                end
            endcase
        end
    end

    // Publish each completed conversion; an unaccepted previous result is overwritten and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (conv_done) begin
            result  <= final_data;
            valid   <= 1'b1;
            overrun <= valid && !bus.result_ready_in;
        end else begin
            overrun <= 1'b0;
            if (bus.result_ready_in) valid <= 1'b0;
        end
    end

    // Weight table reloads only while idle so a running conversion sees a stable table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) weight[i] <= default_weight(i);
        end else if ((state == ST_IDLE) && bus.weight_wr_en_in &&
                     (int'(bus.weight_addr_in) < NUM_STEPS)) begin
            weight[bus.weight_addr_in] <= bus.weight_data_in;
        end
    end

    // Drive the DAC matrix with the trial code while converting and the final code in HOLD.
    always_comb begin
        nswitch_out = '0;
        case (state)
            ST_CONVERT: nswitch_out = trial;
            ST_HOLD:    nswitch_out = data;
            default:    nswitch_out = '0;
        endcase
    end

    assign pswitch_out          = ~nswitch_out;
    assign sample_out           = (state == ST_SAMPLE);
    assign sample_out_n         = ~sample_out;
    assign enable_loop_out      = (state == ST_CONVERT) || (state == ST_HOLD);
    assign busy_out             = (state != ST_IDLE);
    assign overrun_out          = overrun;
    assign bus.result_out       = result;
    assign bus.result_valid_out = valid;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Randomized self-checking bench for adc_sar_sequencer against a step-level
// behavioural model of the successive-approximation search and result handshake.
module tb_adc_sar_sequencer;
    localparam int MB = 12;
    localparam int NS = 15;
    localparam int LS = 4;
    localparam int SC = 1;
    localparam int AW = $clog2(NS);
    localparam logic [MB-1:0] ALL_ONES = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          comparator_in;
    logic          start_in;
    logic          continuous_in;
    logic [2:0]    avg_control_in;
    logic          sample_out;
    logic          sample_out_n;
    logic          enable_loop_out;
    logic [MB-1:0] nswitch_out;
    logic [MB-1:0] pswitch_out;
    logic          busy_out;
    logic          overrun_out;

    int compared   = 0;
    int mismatched = 0;

    logic [MB-1:0] model_weight [NS];
    logic [MB-1:0] model_result = '0;
    bit            model_valid   = 1'b0;
    bit            model_overrun = 1'b0;
    bit            ready_base    = 1'b1;

    adc_sar_sequencer_if #(.MATRIX_BITS(MB), .NUM_STEPS(NS)) bus ();

    adc_sar_sequencer #(
        .MATRIX_BITS   (MB),
        .NUM_STEPS     (NS),
        .LSB_STEPS     (LS),
        .SAMPLE_CYCLES (SC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .comparator_in   (comparator_in),
        .start_in        (start_in),
        .continuous_in   (continuous_in),
        .avg_control_in  (avg_control_in),
        .bus             (bus),
        .sample_out      (sample_out),
        .sample_out_n    (sample_out_n),
        .enable_loop_out (enable_loop_out),
        .nswitch_out     (nswitch_out),
        .pswitch_out     (pswitch_out),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk = ~clk;

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int decisionsFor(input logic [2:0] avg);
        return (avg <= 3'd4) ? ((2 << avg) - 1) : 1;
    endfunction

    function automatic logic [MB-1:0] satAdd(input logic [MB-1:0] a, input logic [MB-1:0] b);
        int s;
        s = int'(a) + int'(b);
        return (s > (1 << MB) - 1) ? ALL_ONES : MB'(s);
    endfunction

    function automatic bit compBit(input int mode, input bit lsb, input int c);
        case (mode)
            1:       return 1'b1;
            2:       return lsb ? ((c % 3) != 2) : 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic void resetModel();
        for (int i = 0; i < NS; i++) model_weight[i] = (i < MB) ? MB'(1 << (MB - 1 - i)) : '0;
        model_result  = '0;
        model_valid   = 1'b0;
        model_overrun = 1'b0;
    endfunction

    // One clock: advance the handshake model at the edge, then compare at the falling edge.
    task automatic tickEdge(input bit complete, input logic [MB-1:0] new_result);
        @(posedge clk);
        if (complete) begin
            model_overrun = model_valid && !bus.result_ready_in;
            model_valid   = 1'b1;
            model_result  = new_result;
        end else begin
            model_overrun = 1'b0;
            if (bus.result_ready_in) model_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("result_valid", bus.result_valid_out, model_valid);
        checkOutput("overrun", overrun_out, model_overrun);
        checkOutput("result", bus.result_out, model_result);
    endtask

    task automatic loadWeight(input int a, input int d);
        bus.weight_wr_en_in = 1'b1;
        bus.weight_addr_in  = AW'(a);
        bus.weight_data_in  = MB'(d);
        tickEdge(1'b0, model_result);
        if (a < NS) model_weight[a] = MB'(d);
        bus.weight_wr_en_in = 1'b0;
    endtask

    task automatic resetMidRun();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy_out, 0);
        checkOutput("abort_valid", bus.result_valid_out, 0);
        checkOutput("abort_nswitch", nswitch_out, 0);
        checkOutput("abort_result", bus.result_out, 0);
        checkOutput("abort_enable_loop", enable_loop_out, 0);
        @(negedge clk);
        rst_n               = 1'b1;
        comparator_in       = 1'b0;
        start_in            = 1'b0;
        continuous_in       = 1'b0;
        bus.weight_wr_en_in = 1'b0;
        resetModel();
        #1;
        checkOutput("release_busy", busy_out, 0);
        checkOutput("release_valid", bus.result_valid_out, 0);
        checkOutput("release_nswitch", nswitch_out, 0);
        @(negedge clk);
    endtask

    // One conversion from IDLE (or from HOLD in continuous mode), ending at the HOLD cycle.
    task automatic applyStimulus(input int mode, input logic [2:0] avg, input bit from_idle,
                                 input bit cont, input bit ready_last, input int abort_step);
        logic [MB-1:0] data_m, trial_m, next_m, inv;
        int n, ones;
        bit b, lsb, last;
        avg_control_in = avg;
        continuous_in  = cont;
        if (from_idle) start_in = 1'b1;
        tickEdge(1'b0, model_result);
        start_in = 1'b0;
        for (int i = 0; i < SC; i++) begin
            checkOutput("sample_out", sample_out, 1);
            checkOutput("sample_out_n", sample_out_n, 0);
            checkOutput("nswitch_sample", nswitch_out, 0);
            checkOutput("pswitch_sample", pswitch_out, ALL_ONES);
            checkOutput("busy_sample", busy_out, 1);
            tickEdge(1'b0, model_result);
        end
        avg_control_in = 3'($urandom);
        data_m = '0;
        next_m = '0;
        for (int s = 0; s < NS; s++) begin
            lsb     = (s >= NS - LS);
            n       = lsb ? decisionsFor(avg) : 1;
            ones    = 0;
            trial_m = satAdd(data_m, model_weight[s]);
            for (int c = 0; c < n; c++) begin
                if (s == abort_step) begin
                    resetMidRun();
                    return;
                end
                b = compBit(mode, lsb, c);
                comparator_in = b;
                ones += int'(b);
                bus.weight_wr_en_in = 1'($urandom_range(0, 1));
                bus.weight_addr_in  = AW'($urandom_range(0, NS - 1));
                bus.weight_data_in  = MB'($urandom);
                last = (s == NS - 1) && (c == n - 1);
                if (last) bus.result_ready_in = ready_last;
                inv = ~trial_m;
                checkOutput("nswitch_trial", nswitch_out, trial_m);
                checkOutput("pswitch_trial", pswitch_out, inv);
                checkOutput("enable_loop", enable_loop_out, 1);
                if (c == n - 1) next_m = (ones * 2 > n) ? trial_m : data_m;
                tickEdge(last, next_m);
            end
            data_m = next_m;
        end
        bus.weight_wr_en_in = 1'b0;
        bus.result_ready_in = ready_base;
        inv = ~data_m;
        checkOutput("nswitch_hold", nswitch_out, data_m);
        checkOutput("pswitch_hold", pswitch_out, inv);
        checkOutput("enable_loop_hold", enable_loop_out, 1);
        checkOutput("busy_hold", busy_out, 1);
        checkOutput("sample_hold", sample_out, 0);
    endtask

    task automatic finishToIdle();
        continuous_in = 1'b0;
        tickEdge(1'b0, model_result);
        checkOutput("busy_idle", busy_out, 0);
        checkOutput("nswitch_idle", nswitch_out, 0);
        checkOutput("pswitch_idle", pswitch_out, ALL_ONES);
        checkOutput("enable_loop_idle", enable_loop_out, 0);
    endtask

    initial begin
        int table_w [NS] = '{2048, 806, 486, 295, 180, 110, 67, 41, 25, 15, 9, 6, 4, 2, 1};
        rst_n               = 1'b0;
        comparator_in       = 1'b0;
        start_in            = 1'b0;
        continuous_in       = 1'b0;
        avg_control_in      = 3'd0;
        bus.weight_wr_en_in = 1'b0;
        bus.weight_addr_in  = '0;
        bus.weight_data_in  = '0;
        bus.result_ready_in = 1'b1;
        resetModel();

        #12;
        checkOutput("reset_busy", busy_out, 0);
        checkOutput("reset_valid", bus.result_valid_out, 0);
        checkOutput("reset_result", bus.result_out, 0);
        checkOutput("reset_overrun", overrun_out, 0);
        checkOutput("reset_nswitch", nswitch_out, 0);
        checkOutput("reset_pswitch", pswitch_out, ALL_ONES);
        checkOutput("reset_sample_n", sample_out_n, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] default weights, comparator held high");
        applyStimulus(1, 3'd0, 1'b1, 1'b0, 1'b1, -1);
        checkOutput("full_scale_default", bus.result_out, 4095);
        finishToIdle();

        $display("[TB] redundant weight table");
        for (int i = 0; i < NS; i++) loadWeight(i, table_w[i]);
        loadWeight(15, 12'h5A5);
        applyStimulus(1, 3'd0, 1'b1, 1'b0, 1'b1, -1);
        checkOutput("full_scale_table", bus.result_out, 4095);
        finishToIdle();

        $display("[TB] averaged LSB steps, vote pattern 1,1,0");
        applyStimulus(2, 3'd1, 1'b1, 1'b0, 1'b1, -1);
        checkOutput("avg3_lsb_only", bus.result_out, 13);
        finishToIdle();

        $display("[TB] random weights, averaging and comparator");
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) loadWeight($urandom_range(0, 15), $urandom_range(0, 4095));
            applyStimulus(0, 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b1, -1);
            finishToIdle();
        end

        $display("[TB] saturation of the trial code");
        loadWeight(0, 4095);
        loadWeight(1, 3000);
        applyStimulus(1, 3'd0, 1'b1, 1'b0, 1'b1, -1);
        checkOutput("saturated", bus.result_out, 4095);
        finishToIdle();

        $display("[TB] continuous mode with held-off consumer");
        ready_base = 1'b0;
        bus.result_ready_in = 1'b0;
        applyStimulus(0, 3'd2, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("first_no_overrun", overrun_out, 0);
        applyStimulus(0, 3'd0, 1'b0, 1'b1, 1'b0, -1);
        checkOutput("second_overrun", overrun_out, 1);
        applyStimulus(1, 3'd0, 1'b0, 1'b1, 1'b1, -1);
        checkOutput("accept_on_complete_overrun", overrun_out, 0);
        checkOutput("accept_on_complete_valid", bus.result_valid_out, 1);
        ready_base = 1'b1;
        bus.result_ready_in = 1'b1;
        finishToIdle();

        $display("[TB] reset during conversion step 5");
        applyStimulus(1, 3'd0, 1'b1, 1'b0, 1'b1, 5);
        applyStimulus(1, 3'd0, 1'b1, 1'b0, 1'b1, -1);
        checkOutput("after_abort", bus.result_out, 4095);
        finishToIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
